// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared constants, FSM state encoding and frame helpers for the UART transmit
// scheduler.
//
// Contents:
//   NUM_REQ   default number of message requesters
//              (0 = deal, 1 = dealer finished, 2 = player select)
//   MAX_LEN   default maximum payload bytes per frame
//   SOF       default start-of-frame byte
//   IDX_W     width of a requester index (grant_id, round-robin pointer)
//   LEN_W     width of a payload length field
//   DATA_W    width of a payload field (MAX_LEN bytes, first byte in the MSBs)
//   state_e   frame FSM states
//   type_byte frame type byte builder
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  localparam int         NUM_REQ = 3;
  localparam int         MAX_LEN = 3;
  localparam logic [7:0] SOF     = 8'hA5;

  localparam int IDX_W  = 2;
  localparam int LEN_W  = 2;
  localparam int DATA_W = 24;

  // Every state except ST_IDLE presents exactly one byte on w_data.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF     = 3'd1,
    ST_TYPE    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } state_e;

  // Type byte layout: [7:6] requester id, [5:2] reserved zero, [1:0] length.
  function automatic logic [7:0] type_byte(input logic [IDX_W-1:0] id,
                                           input logic [LEN_W-1:0] len);
    return {id, 2'b00, 2'b00, len};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. Starting at 'pointer' and wrapping
// modulo N, returns the first requester whose pending bit is set.
//
// Ports:
//   pending  in   N    one bit per requester with a frame waiting
//   pointer  in   IW   index where the search starts (0..N-1)
//   valid    out  1    at least one pending bit is set
//   index    out  IW   selected requester; 0 when valid=0
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] pointer,
  output logic          valid,
  output logic [IW-1:0] index
);

  int j;

  always_comb begin
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      // pointer is always < N, so a single subtraction performs the wrap.
      j = int'(pointer) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (!valid && pending[j]) begin
        valid = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Collects one-cycle message requests from NUM_REQ requesters, arbitrates
// between them round-robin and serialises each message as a frame into a UART
// transmit FIFO:
//   SOF, type = {id, 4'b0000, len}, len payload bytes, checksum
// The checksum is the XOR of the type byte and the payload bytes.
//
// Handshake: a byte is transferred on every rising edge where wr_uart=1.
// wr_uart is high whenever the FSM is in a byte state and tx_full=0; while
// tx_full=1 the byte on w_data is held and the FSM does not advance.
//
// Ports:
//   clk        in   1            system clock, rising edge
//   rst        in   1            asynchronous active-low reset
//   req        in   NUM_REQ      per-requester request pulse
//   req_len    in   NUM_REQ*2    per-requester payload length, sampled with req
//   req_data   in   NUM_REQ*24   per-requester payload, [23:16] sent first
//   tx_full    in   1            UART transmit FIFO full
//   wr_uart    out  1            write strobe into the UART transmit FIFO
//   w_data     out  8            byte to write, valid with wr_uart
//   busy       out  1            FSM is not IDLE
//   grant_id   out  2            requester being served, valid while busy
//   done       out  NUM_REQ      pulse the cycle after a frame's last byte
//   overflow   out  NUM_REQ      sticky: a request from that requester dropped
//   dbg_state  out  state_e      current FSM state, for observation only
// -----------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_tx_pkg::*;
#(
  parameter int         NUM_REQ = uart_tx_pkg::NUM_REQ,
  parameter int         MAX_LEN = uart_tx_pkg::MAX_LEN,
  parameter logic [7:0] SOF     = uart_tx_pkg::SOF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      tx_full,
  output logic                      wr_uart,
  output logic [7:0]                w_data,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        overflow,
  output state_e                    dbg_state
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_REQ - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  logic [NUM_REQ-1:0]             pending_q, pending_d;
  logic [NUM_REQ-1:0][LEN_W-1:0]  len_lat_q, len_lat_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_lat_q, data_lat_d;

  // Shadow copy of the granted request; the payload shifts left one byte per
  // payload write so the next byte is always in the top 8 bits.
  logic [LEN_W-1:0]  sh_len_q, sh_len_d;
  logic [DATA_W-1:0] sh_data_q, sh_data_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;       // payload bytes still to write
  logic [7:0]        csum_q, csum_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;       // round-robin search start
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic             arb_valid;
  logic [IDX_W-1:0] arb_idx;
  logic             grant;
  logic             wr;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_arb (
    .pending (pending_q),
    .pointer (ptr_q),
    .valid   (arb_valid),
    .index   (arb_idx)
  );

  assign grant = (state_q == ST_IDLE) && arb_valid;
  assign wr    = (state_q != ST_IDLE) && !tx_full;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant) state_d = ST_SOF;
      ST_SOF:     if (wr)    state_d = ST_TYPE;
      ST_TYPE:    if (wr)    state_d = (sh_len_q == '0) ? ST_CSUM : ST_PAYLOAD;
      ST_PAYLOAD: if (wr && (cnt_q == LEN_W'(1))) state_d = ST_CSUM;
      ST_CSUM:    if (wr)    state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_data = 8'h00;
    case (state_q)
      ST_SOF:     w_data = SOF;
      ST_TYPE:    w_data = type_byte(grant_q, sh_len_q);
      ST_PAYLOAD: w_data = sh_data_q[DATA_W-1 -: 8];
      ST_CSUM:    w_data = csum_q;
      default:    w_data = 8'h00;
    endcase
  end

  assign wr_uart   = wr;
  assign busy      = (state_q != ST_IDLE);
  assign grant_id  = grant_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  logic [LEN_W-1:0] len_in;

  always_comb begin
    pending_d  = pending_q;
    len_lat_d  = len_lat_q;
    data_lat_d = data_lat_q;
    sh_len_d   = sh_len_q;
    sh_data_d  = sh_data_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    done_d     = '0;
    ovf_d      = ovf_q;
    len_in     = '0;

    // Grant: move the latched request into the shadow and free the slot.
    if (grant) begin
      pending_d[arb_idx] = 1'b0;
      sh_len_d           = len_lat_q[arb_idx];
      sh_data_d          = data_lat_q[arb_idx];
      grant_d            = arb_idx;
      ptr_d              = (arb_idx == IDX_TOP) ? '0 : arb_idx + IDX_W'(1);
    end

    // Request capture. A slot being granted this cycle counts as free, so a
    // request on the grant cycle becomes the next pending request.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        if (!pending_q[i] || (grant && (arb_idx == IDX_W'(i)))) begin
          len_in = req_len[i*LEN_W +: LEN_W];
          if (len_in > LEN_MAX) begin
            len_in = LEN_MAX;
          end
          pending_d[i]  = 1'b1;
          len_lat_d[i]  = len_in;
          data_lat_d[i] = req_data[i*DATA_W +: DATA_W];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end

    // Frame progress, only on cycles where a byte is actually written.
    if (wr) begin
      case (state_q)
        ST_TYPE: begin
          csum_d = type_byte(grant_q, sh_len_q);
          cnt_d  = sh_len_q;
        end
        ST_PAYLOAD: begin
          csum_d    = csum_q ^ sh_data_q[DATA_W-1 -: 8];
          sh_data_d = {sh_data_q[DATA_W-9:0], 8'h00};
          cnt_d     = cnt_q - LEN_W'(1);
        end
        ST_CSUM: begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_W'(i)) begin
              done_d[i] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      len_lat_q  <= '0;
      data_lat_q <= '0;
      sh_len_q   <= '0;
      sh_data_q  <= '0;
      cnt_q      <= '0;
      csum_q     <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      ovf_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      len_lat_q  <= len_lat_d;
      data_lat_q <= data_lat_d;
      sh_len_q   <= sh_len_d;
      sh_data_q  <= sh_data_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed scenarios for uart_tx_scheduler. A monitor logs every written byte
// and every done pulse with the cycle it was observed in; each scenario task
// compares those logs against hand-computed frames.
// Cycle stamps: 'cyc' counts rising edges; a byte logged at stamp s is
// committed into the FIFO at rising edge s+1.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;
  import uart_tx_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [5:0]  req_len;
  logic [71:0] req_data;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        busy;
  logic [1:0]  grant_id;
  logic [2:0]  done;
  logic [2:0]  overflow;
  state_e      dbg_state;

  always #5 clk = ~clk;

  uart_tx_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_len   (req_len),
    .req_data  (req_data),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .busy      (busy),
    .grant_id  (grant_id),
    .done      (done),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  logic [7:0] wr_q[$];
  int         wr_cyc_q[$];
  logic [2:0] done_q[$];
  int         done_cyc_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  always @(negedge clk) begin
    if (wr_uart === 1'b1) begin
      wr_q.push_back(w_data);
      wr_cyc_q.push_back(cyc);
    end
    if (done !== 3'b000) begin
      done_q.push_back(done);
      done_cyc_q.push_back(cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    wr_q.delete();
    wr_cyc_q.delete();
    done_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    req      = '0;
    req_len  = '0;
    req_data = '0;
    tx_full  = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic set_req(input int i, input logic [1:0] len, input logic [23:0] data);
    req[i]               = 1'b1;
    req_len[2*i +: 2]    = len;
    req_data[24*i +: 24] = data;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst      = 1'b0;
    req      = '0;
    req_len  = '0;
    req_data = '0;
    tx_full  = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({wr_uart, w_data} !== 9'h000) begin
      tests_failed++;
      $display("FAIL reset_wr: wr_uart/w_data got %b/%h expected 0/00", wr_uart, w_data);
    end
    tests_run++;
    if ({busy, grant_id} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_busy: busy/grant_id got %b/%0d expected 0/0", busy, grant_id);
    end
    tests_run++;
    if ({done, overflow} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: done/overflow got %b/%b expected 000/000", done, overflow);
    end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic test_single_frame();
    int t;
    do_reset();
    set_req(0, 2'd2, 24'h0A0B00);
    tick();
    t   = cyc;
    req = '0;
    repeat (12) tick();
    exp_q = '{8'hA5, 8'h02, 8'h0A, 8'h0B, 8'h03};
    tests_run++;
    if (wr_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL single_count: got %0d bytes expected %0d", wr_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < wr_q.size()) begin
        tests_run++;
        if (wr_q[k] !== exp_q[k] || wr_cyc_q[k] != t + 1 + k) begin
          tests_failed++;
          $display("FAIL single_byte%0d: got %h@%0d expected %h@%0d",
                   k, wr_q[k], wr_cyc_q[k], exp_q[k], t + 1 + k);
        end
      end
    end
    tests_run++;
    if (done_q.size() != 1) begin
      tests_failed++;
      $display("FAIL single_done_count: got %0d pulses expected 1", done_q.size());
    end else begin
      tests_run++;
      if (done_q[0] !== 3'b001 || done_cyc_q[0] != t + 6) begin
        tests_failed++;
        $display("FAIL single_done: got %b@%0d expected 001@%0d", done_q[0], done_cyc_q[0], t + 6);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int exp_cyc[6];
    do_reset();
    set_req(1, 2'd0, 24'h000000);
    set_req(2, 2'd0, 24'h000000);
    tick();
    t   = cyc;
    req = '0;
    repeat (14) tick();
    exp_q   = '{8'hA5, 8'h40, 8'h40, 8'hA5, 8'h80, 8'h80};
    exp_cyc = '{t + 1, t + 2, t + 3, t + 5, t + 6, t + 7};
    tests_run++;
    if (wr_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d bytes expected %0d", wr_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < wr_q.size()) begin
        tests_run++;
        if (wr_q[k] !== exp_q[k] || wr_cyc_q[k] != exp_cyc[k]) begin
          tests_failed++;
          $display("FAIL b2b_byte%0d: got %h@%0d expected %h@%0d",
                   k, wr_q[k], wr_cyc_q[k], exp_q[k], exp_cyc[k]);
        end
      end
    end
    tests_run++;
    if (done_q.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_done_count: got %0d pulses expected 2", done_q.size());
    end else begin
      tests_run++;
      if (done_q[0] !== 3'b010 || done_cyc_q[0] != t + 4 ||
          done_q[1] !== 3'b100 || done_cyc_q[1] != t + 8) begin
        tests_failed++;
        $display("FAIL b2b_done: got %b@%0d,%b@%0d expected 010@%0d,100@%0d",
                 done_q[0], done_cyc_q[0], done_q[1], done_cyc_q[1], t + 4, t + 8);
      end
    end
  endtask

  task automatic test_stall();
    int t;
    do_reset();
    set_req(0, 2'd3, 24'h112233);
    tick();
    t   = cyc;
    req = '0;
    repeat (4) tick();        // 0x11 committed, 0x22 now on w_data
    tx_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (wr_uart !== 1'b0 || w_data !== 8'h22 || dbg_state !== ST_PAYLOAD) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: wr/data/state got %b/%h/%0d expected 0/22/%0d",
                 k, wr_uart, w_data, dbg_state, ST_PAYLOAD);
      end
      tick();
    end
    tx_full = 1'b0;
    repeat (10) tick();
    exp_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    tests_run++;
    if (wr_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d bytes expected %0d", wr_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < wr_q.size()) begin
        tests_run++;
        if (wr_q[k] !== exp_q[k]) begin
          tests_failed++;
          $display("FAIL stall_byte%0d: got %h expected %h", k, wr_q[k], exp_q[k]);
        end
      end
    end
    if (wr_cyc_q.size() > 3) begin
      tests_run++;
      if (wr_cyc_q[2] != t + 3 || wr_cyc_q[3] != t + 8) begin
        tests_failed++;
        $display("FAIL stall_timing: got %0d,%0d expected %0d,%0d",
                 wr_cyc_q[2], wr_cyc_q[3], t + 3, t + 8);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    set_req(1, 2'd0, 24'h000000);
    tick();                   // requester 1 pending
    req = '0;
    set_req(0, 2'd0, 24'h000000);
    tick();                   // grant 1; requester 0 becomes pending
    tick();                   // requester 0 still pending and not granted: drop
    req = '0;
    repeat (14) tick();
    exp_q = '{8'hA5, 8'h40, 8'h40, 8'hA5, 8'h00, 8'h00};
    tests_run++;
    if (wr_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL ovf_count: got %0d bytes expected %0d", wr_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < wr_q.size()) begin
        tests_run++;
        if (wr_q[k] !== exp_q[k]) begin
          tests_failed++;
          $display("FAIL ovf_byte%0d: got %h expected %h", k, wr_q[k], exp_q[k]);
        end
      end
    end
    tests_run++;
    if (overflow !== 3'b001) begin
      tests_failed++;
      $display("FAIL ovf_flag: got %b expected 001", overflow);
    end
  endtask

  task automatic test_grant_cycle_req();
    do_reset();
    set_req(0, 2'd0, 24'h000000);
    tick();                   // requester 0 pending
    set_req(0, 2'd1, 24'h7F0000);
    tick();                   // grant edge: second request is accepted
    req = '0;
    repeat (14) tick();
    exp_q = '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'h01, 8'h7F, 8'h7E};
    tests_run++;
    if (wr_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL gcr_count: got %0d bytes expected %0d", wr_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < wr_q.size()) begin
        tests_run++;
        if (wr_q[k] !== exp_q[k]) begin
          tests_failed++;
          $display("FAIL gcr_byte%0d: got %h expected %h", k, wr_q[k], exp_q[k]);
        end
      end
    end
    tests_run++;
    if (overflow !== 3'b000 || done_q.size() != 2) begin
      tests_failed++;
      $display("FAIL gcr_flags: overflow/done pulses got %b/%0d expected 000/2",
               overflow, done_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    set_req(0, 2'd2, 24'h0A0B00);
    tick();
    req = '0;
    repeat (5) tick();        // checksum byte now on w_data
    tests_run++;
    if (dbg_state !== ST_CSUM) begin
      tests_failed++;
      $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, ST_CSUM);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({wr_uart, w_data, busy, grant_id, done, overflow} !== 18'h0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: wr/data/busy/gid/done/ovf got %b/%h/%b/%0d/%b/%b expected all 0",
               wr_uart, w_data, busy, grant_id, done, overflow);
    end
    tick();
    rst = 1'b1;
    repeat (6) tick();
    exp_q = '{8'hA5, 8'h02, 8'h0A, 8'h0B};
    tests_run++;
    if (wr_q.size() != exp_q.size() || done_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rstmid_abort: bytes/done pulses got %0d/%0d expected 4/0",
               wr_q.size(), done_q.size());
    end
    clear_logs();
    set_req(2, 2'd1, 24'h550000);
    tick();
    req = '0;
    repeat (10) tick();
    exp_q = '{8'hA5, 8'h81, 8'h55, 8'hD4};
    tests_run++;
    if (wr_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rstmid_count: got %0d bytes expected %0d", wr_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < wr_q.size()) begin
        tests_run++;
        if (wr_q[k] !== exp_q[k]) begin
          tests_failed++;
          $display("FAIL rstmid_byte%0d: got %h expected %h", k, wr_q[k], exp_q[k]);
        end
      end
    end
    tests_run++;
    if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] !== 3'b100)) begin
      tests_failed++;
      $display("FAIL rstmid_done: got %0d pulses expected one 100", done_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_type;
    do_reset();
    set_req(0, 2'd0, 24'h000000);
    set_req(1, 2'd0, 24'h000000);
    set_req(2, 2'd0, 24'h000000);
    tick();
    repeat (26) tick();
    req = '0;
    repeat (16) tick();
    tests_run++;
    if (wr_q.size() < 18) begin
      tests_failed++;
      $display("FAIL rr_count: got %0d bytes expected at least 18", wr_q.size());
    end
    for (int f = 0; f < 6; f++) begin
      if (3 * f + 2 < wr_q.size()) begin
        exp_type = {2'(f % 3), 6'b000000};
        tests_run++;
        if (wr_q[3*f] !== 8'hA5 || wr_q[3*f+1] !== exp_type || wr_q[3*f+2] !== exp_type) begin
          tests_failed++;
          $display("FAIL rr_frame%0d: got %h %h %h expected a5 %h %h",
                   f, wr_q[3*f], wr_q[3*f+1], wr_q[3*f+2], exp_type, exp_type);
        end
      end
    end
    tests_run++;
    if (overflow !== 3'b111) begin
      tests_failed++;
      $display("FAIL rr_overflow: got %b expected 111", overflow);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_grant_cycle_req();
    test_reset_mid_frame();
    test_round_robin();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 3, number of message requesters (0 = deal, 1 = dealer finished, 2 = player select).
REQ-002 Parameter MAX_LEN, default 3, maximum payload bytes per frame.
REQ-003 Parameter SOF, default 8'hA5, start-of-frame byte.
REQ-004 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 req  input  NUM_REQ  per-requester one-cycle request pulse.
REQ-007 req_len  input  NUM_REQ x 2  per-requester payload length, 0..3, sampled with req.
REQ-008 req_data  input  NUM_REQ x 24  per-requester payload, sampled with req; bits [23:16] are sent first.
REQ-009 tx_full  input  1  UART transmit FIFO full.
REQ-010 wr_uart  output  1  write strobe to the UART transmit FIFO.
REQ-011 w_data  output  8  byte to write; valid when wr_uart=1.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 grant_id  output  2  index of the requester being served; valid while busy=1.
REQ-014 done  output  NUM_REQ  one-cycle pulse when that requester's frame has been fully written.
REQ-015 overflow  output  NUM_REQ  sticky flag: a request was dropped.

Function
REQ-016 Each requester SHALL own a pending bit plus latched req_len and req_data, loaded on req when its pending bit is 0.
REQ-017 A req arriving while pending=1 and the frame is not yet granted SHALL be dropped and SHALL set overflow[i].
REQ-018 A grant SHALL clear pending[i] and copy the latch into a shadow register; a req on the grant cycle SHALL be accepted as a new pending request.
REQ-019 Arbitration SHALL be round-robin: after serving i, the search starts at i+1 (mod NUM_REQ); the first search after reset starts at 0.
REQ-020 FSM states SHALL be IDLE, SOF, TYPE, PAYLOAD, CSUM.
REQ-021 In IDLE with any pending bit set, the block SHALL grant and move to SOF on the next edge.
REQ-022 In SOF, TYPE, PAYLOAD and CSUM, wr_uart SHALL be combinational: state is a byte state AND tx_full=0.
REQ-023 When tx_full=1 the byte SHALL be held and the state SHALL NOT advance.
REQ-024 Byte order SHALL be: SOF; type = {2'(grant_id), 2'b00, 2'b00, 2'(len)}; len payload bytes; checksum.
REQ-025 Checksum SHALL be the XOR of the type byte and all payload bytes; SOF is excluded.
REQ-026 len=0 SHALL skip PAYLOAD (TYPE goes straight to CSUM).
REQ-027 After the checksum is written, the FSM SHALL return to IDLE; done[grant_id] SHALL pulse on the following cycle.
REQ-028 Latency: req at edge t gives the SOF write at cycle t+2 when tx_full=0; a frame with tx_full held 0 uses len+3 consecutive writes.
REQ-029 Back-to-back frames SHALL have exactly one IDLE cycle between them.

Reset
REQ-030 On reset, state SHALL be IDLE and pending, latches, shadow, round-robin pointer, overflow, done, grant_id and busy SHALL all be 0.
REQ-031 On reset, wr_uart SHALL be 0 and w_data SHALL be 8'h00.
REQ-032 Reset mid-frame SHALL abort the frame with no done pulse; the receiver resynchronises on SOF.

Structure
REQ-033 Package uart_tx_pkg SHALL hold SOF, NUM_REQ, MAX_LEN and the FSM state enum.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: pending, pointer; outputs: valid, index).
REQ-035 Implementation size SHALL be 120-400 lines of RTL.

Verification
REQ-036 Scenario 1: req[0], len=2, data=24'h0A0B00, tx_full=0 -> writes A5,02,0A,0B,03 on consecutive cycles, then done[0].
REQ-037 Scenario 2: req[1] and req[2] on the same cycle, both len=0 -> frame 1 (A5,40,40) then frame 2 (A5,80,80), one IDLE cycle apart.
REQ-038 Scenario 3: tx_full=1 for 4 cycles during PAYLOAD -> no wr_uart during the stall, w_data stable, byte sequence unchanged.
REQ-039 Scenario 4: second req[0] before grant -> overflow[0]=1, only one frame sent; a req[0] on the grant cycle -> two frames sent.
REQ-040 Scenario 5: rst low during CSUM -> all outputs 0 next cycle, no done; a new req after release gives a normal frame.
REQ-041 Scenario 6: all three requesters continuously re-requesting -> grant order 0,1,2,0,1,2.
